// File: rtl/blob_pkg.sv
// blob_pkg: FSM state encoding and default parameters for the blob counter.
package blob_pkg;

   typedef enum logic [2:0] {IDLE, CLEAR, SCAN, ACCUM, FINDMAX, COUNT, DONE} state_t;

   localparam int DEF_IMG_W        = 640;
   localparam int DEF_IMG_H        = 480;
   localparam int DEF_LABEL_W      = 7;
   localparam int DEF_AREA_W       = 19;
   localparam int DEF_THRESH_SHIFT = 3;
   localparam int DEF_CONN8        = 1;

endpackage

// File: rtl/blob_line_buffer.sv
// blob_line_buffer: previous-row label store, read one column while writing another.
module blob_line_buffer #(
   parameter int IMG_W   = 640,
   parameter int LABEL_W = 7,
   parameter int XW      = (IMG_W > 1) ? $clog2(IMG_W) : 1
) (
   input  logic               clk,
   input  logic               we,
   input  logic [XW-1:0]      wr_x,
   input  logic [LABEL_W-1:0] wr_label,
   input  logic [XW-1:0]      rd_x,
   output logic [LABEL_W-1:0] rd_label
);

   logic [LABEL_W-1:0] mem [IMG_W];

   always_ff @(posedge clk)
      if (we) mem[wr_x] <= wr_label;

   assign rd_label = mem[rd_x];

endmodule

// File: rtl/blob_counter.sv
// blob_counter: single-pass connected-component labelling with area threshold count.
module blob_counter
   import blob_pkg::*;
#(
   parameter int IMG_W        = DEF_IMG_W,
   parameter int IMG_H        = DEF_IMG_H,
   parameter int LABEL_W      = DEF_LABEL_W,
   parameter int AREA_W       = DEF_AREA_W,
   parameter int THRESH_SHIFT = DEF_THRESH_SHIFT,
   parameter int CONN8        = DEF_CONN8
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_start,
   input  logic               i_valid,
   input  logic               i_pixel,
   output logic               o_ready,
   output logic               o_busy,
   output logic               o_valid,
   output logic [LABEL_W-1:0] o_count,
   output logic [AREA_W-1:0]  o_max_area,
   output logic               o_overflow
);

   localparam int N  = 2 ** LABEL_W;
   localparam int XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
   localparam int YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
   localparam logic [LABEL_W:0] LBL_END = (LABEL_W + 1)'(N);

   typedef logic [LABEL_W-1:0] lbl_t;
   typedef logic [AREA_W-1:0]  area_t;

   function automatic area_t sat_add(input area_t a, input area_t b);
      logic [AREA_W:0] s;
      s = {1'b0, a} + {1'b0, b};
      return s[AREA_W] ? '1 : s[AREA_W-1:0];
   endfunction

   function automatic lbl_t min_nz(input lbl_t a, input lbl_t b);
      return (a == '0) ? b : (b == '0) ? a : (a < b) ? a : b;
   endfunction

   state_t state, state_nx;

   lbl_t  parent [N];
   area_t area   [N];

   lbl_t           idx;
   logic [LABEL_W:0] next_label;
   logic [XW-1:0]  x;
   logic [YW-1:0]  y;
   lbl_t           l_reg, u_reg, ul_reg, row0;
   logic           overflow;
   area_t          max_area;
   lbl_t           count;

   logic  take, idx_last, x_last, y_last, fresh, drop, do_merge, root_i, inc;
   lbl_t  ur_raw, nl, nul, nu, nur, cul, cur, nb, lbl, ma, mb, ra, rb, root, cnt_nx;
   logic  p_we, a_we;
   lbl_t  p_wa, p_wd, a_wa;
   area_t a_wd;

   assign take     = (state == SCAN) && i_valid;
   assign idx_last = idx == lbl_t'(N - 1);
   assign x_last   = x == XW'(IMG_W - 1);
   assign y_last   = y == YW'(IMG_H - 1);

   blob_line_buffer #(.IMG_W(IMG_W), .LABEL_W(LABEL_W), .XW(XW)) u_line (
      .clk      (i_clk),
      .we       (take),
      .wr_x     (x),
      .wr_label (lbl),
      .rd_x     (x_last ? '0 : x + XW'(1)),
      .rd_label (ur_raw)
   );

   // Edge neighbours are masked here so the buffer never needs clearing.
   always_comb begin
      nl       = (x == '0) ? '0 : l_reg;
      nul      = (x == '0 || y == '0) ? '0 : ul_reg;
      nu       = (y == '0) ? '0 : u_reg;
      nur      = (y == '0 || x_last) ? '0 : ur_raw;
      cul      = (CONN8 != 0) ? nul : '0;
      cur      = (CONN8 != 0) ? nur : '0;
      nb       = min_nz(min_nz(nl, nu), min_nz(cul, cur));
      fresh    = i_pixel && (nb == '0);
      drop     = fresh && (next_label == LBL_END);
      lbl      = !i_pixel ? '0 : !fresh ? nb : drop ? '0 : next_label[LABEL_W-1:0];
      ma       = (CONN8 != 0 && nl == '0) ? nul : nl;
      mb       = (CONN8 == 0) ? nu : (nu != '0) ? '0 : nur;
      ra       = parent[ma];
      rb       = parent[mb];
      do_merge = take && i_pixel && (ma != '0) && (mb != '0) && (ra != rb);
      root     = parent[parent[idx]];
      root_i   = parent[idx] == idx;
      inc      = root_i && (area[idx] != '0) && (area[idx] > (max_area >> THRESH_SHIFT));
      cnt_nx   = count + lbl_t'(inc);
   end

   // Areas are folded into roots during ACCUM; non-root entries are ignored afterwards.
   always_comb begin
      p_we = (state == CLEAR) || (state == ACCUM) || do_merge;
      p_wa = (state == SCAN) ? ((ra > rb) ? ra : rb) : idx;
      p_wd = (state == CLEAR) ? idx : (state == ACCUM) ? root : ((ra < rb) ? ra : rb);
      a_we = (state == CLEAR) || (state == ACCUM && root != idx) || (take && lbl != '0);
      a_wa = (state == ACCUM) ? root : (state == SCAN) ? lbl : idx;
      a_wd = (state == CLEAR) ? '0
           : (state == ACCUM) ? sat_add(area[root], area[idx])
           : fresh ? area_t'(1) : sat_add(area[lbl], area_t'(1));
   end

   always_ff @(posedge i_clk) begin
      if (p_we) parent[p_wa] <= p_wd;
      if (a_we) area[a_wa] <= a_wd;
   end

   always_ff @(posedge i_clk)
      if (i_rst) state <= IDLE;
      else       state <= state_nx;

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:    state_nx = i_start ? CLEAR : IDLE;
         CLEAR:   state_nx = idx_last ? SCAN : CLEAR;
         SCAN:    state_nx = (take && x_last && y_last) ? ACCUM : SCAN;
         ACCUM:   state_nx = idx_last ? FINDMAX : ACCUM;
         FINDMAX: state_nx = idx_last ? COUNT : FINDMAX;
         COUNT:   state_nx = idx_last ? DONE : COUNT;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      o_ready = state == SCAN;
      o_busy  = state != IDLE;
      o_valid = state == DONE;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         idx        <= '0;
         next_label <= '0;
         x          <= '0;
         y          <= '0;
         l_reg      <= '0;
         u_reg      <= '0;
         ul_reg     <= '0;
         row0       <= '0;
         overflow   <= 1'b0;
         max_area   <= '0;
         count      <= '0;
         o_count    <= '0;
         o_max_area <= '0;
         o_overflow <= 1'b0;
      end else begin
         idx <= (state == CLEAR || state == ACCUM || state == FINDMAX || state == COUNT) ? idx + lbl_t'(1) : '0;
         if (state == IDLE && i_start) begin
            next_label <= (LABEL_W + 1)'(1);
            overflow   <= 1'b0;
            x          <= '0;
            y          <= '0;
            max_area   <= '0;
            count      <= '0;
         end
         if (take) begin
            x      <= x_last ? '0 : x + XW'(1);
            y      <= x_last ? y + YW'(1) : y;
            l_reg  <= lbl;
            ul_reg <= x_last ? '0 : u_reg;
            u_reg  <= x_last ? ((x == '0) ? lbl : row0) : ur_raw;
            row0   <= (x == '0) ? lbl : row0;
            if (fresh && !drop) next_label <= next_label + (LABEL_W + 1)'(1);
            if (drop) overflow <= 1'b1;
         end
         if (state == FINDMAX && root_i && area[idx] > max_area) max_area <= area[idx];
         if (state == COUNT) count <= cnt_nx;
         if (state == COUNT && idx_last) begin
            o_count    <= cnt_nx;
            o_max_area <= max_area;
            o_overflow <= overflow;
         end
      end
   end

endmodule

// File: tb/tb_blob_counter.sv
// tb_blob_counter: directed frames against four small blob_counter configurations.
module tb_blob_counter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic             rst;
   logic [3:0]       start, valid, pixel;
   logic [3:0]       ready, busy, done, ovf;
   logic [3:0][2:0]  cnt;
   logic [18:0]      m0, m1, m2;
   logic [3:0]       m3;
   logic [127:0]     img;

   int n_tests = 0;
   int n_fail  = 0;
   int pulses  = 0;
   int p0;
   int r_cnt, r_mx, r_ovf;

   blob_counter #(.IMG_W(8), .IMG_H(4), .LABEL_W(3), .CONN8(1)) u0 (
      .i_clk(clk), .i_rst(rst), .i_start(start[0]), .i_valid(valid[0]), .i_pixel(pixel[0]),
      .o_ready(ready[0]), .o_busy(busy[0]), .o_valid(done[0]), .o_count(cnt[0]),
      .o_max_area(m0), .o_overflow(ovf[0]));

   blob_counter #(.IMG_W(8), .IMG_H(4), .LABEL_W(3), .CONN8(0)) u1 (
      .i_clk(clk), .i_rst(rst), .i_start(start[1]), .i_valid(valid[1]), .i_pixel(pixel[1]),
      .o_ready(ready[1]), .o_busy(busy[1]), .o_valid(done[1]), .o_count(cnt[1]),
      .o_max_area(m1), .o_overflow(ovf[1]));

   blob_counter #(.IMG_W(16), .IMG_H(8), .LABEL_W(3), .CONN8(1)) u2 (
      .i_clk(clk), .i_rst(rst), .i_start(start[2]), .i_valid(valid[2]), .i_pixel(pixel[2]),
      .o_ready(ready[2]), .o_busy(busy[2]), .o_valid(done[2]), .o_count(cnt[2]),
      .o_max_area(m2), .o_overflow(ovf[2]));

   blob_counter #(.IMG_W(8), .IMG_H(4), .LABEL_W(3), .AREA_W(4), .CONN8(1)) u3 (
      .i_clk(clk), .i_rst(rst), .i_start(start[3]), .i_valid(valid[3]), .i_pixel(pixel[3]),
      .o_ready(ready[3]), .o_busy(busy[3]), .o_valid(done[3]), .o_count(cnt[3]),
      .o_max_area(m3), .o_overflow(ovf[3]));

   always @(negedge clk) if (done[0] === 1'b1) pulses++;

   function automatic logic [18:0] mxv(input int k);
      return (k == 0) ? m0 : (k == 1) ? m1 : (k == 2) ? m2 : {15'd0, m3};
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic rect(input int x0, input int y0, input int x1, input int y1, input int w);
      for (int yy = y0; yy <= y1; yy++)
         for (int xx = x0; xx <= x1; xx++)
            img[yy * w + xx] = 1'b1;
   endtask

   task automatic run_frame(input string tag, input int k, input int np, input bit stall);
      int  p, g, lat;
      logic acc;
      start[k] = 1'b1;
      @(negedge clk);
      start[k] = 1'b0;
      check({tag, "_clear_ready"}, 32'(ready[k]), 0);
      check({tag, "_clear_busy"}, 32'(busy[k]), 1);
      p = 0;
      g = 0;
      while (p < np && g < 5000) begin
         valid[k] = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
         pixel[k] = img[p];
         start[k] = stall && (p == 5);
         acc = valid[k] && ready[k];
         @(negedge clk);
         g++;
         if (acc) p++;
      end
      valid[k] = 1'b0;
      pixel[k] = 1'b0;
      start[k] = 1'b0;
      check({tag, "_pixels"}, p, np);
      lat = 0;
      while (!done[k] && lat < 200) begin
         @(negedge clk);
         lat++;
      end
      check({tag, "_latency"}, lat + 1, 25);
      r_cnt = int'(cnt[k]);
      r_mx  = int'(mxv(k));
      r_ovf = int'(ovf[k]);
      @(negedge clk);
      check({tag, "_strobe_once"}, 32'(done[k]), 0);
      check({tag, "_idle"}, 32'(busy[k]), 0);
   endtask

   task automatic result(input string tag, input int c, input int m, input int o);
      check({tag, "_count"}, r_cnt, c);
      check({tag, "_max_area"}, r_mx, m);
      check({tag, "_overflow"}, r_ovf, o);
   endtask

   initial begin
      rst   = 1'b1;
      start = '0;
      valid = '0;
      pixel = '0;
      img   = '0;
      repeat (3) @(negedge clk);
      check("rst_ready", 32'(ready[0]), 0);
      check("rst_busy", 32'(busy[0]), 0);
      check("rst_valid", 32'(done[0]), 0);
      check("rst_count", 32'(cnt[0]), 0);
      check("rst_max", 32'(m0), 0);
      check("rst_ovf", 32'(ovf[0]), 0);
      rst = 1'b0;
      @(negedge clk);

      img = '0;
      rect(0, 0, 1, 1, 8);
      rect(6, 2, 7, 3, 8);
      run_frame("sq8", 0, 32, 0);
      result("sq8", 2, 4, 0);
      run_frame("sq4", 1, 32, 0);
      result("sq4", 2, 4, 0);

      img = '0;
      rect(1, 0, 1, 3, 8);
      rect(5, 0, 5, 3, 8);
      rect(1, 3, 5, 3, 8);
      run_frame("u8", 0, 32, 0);
      result("u8", 1, 11, 0);
      run_frame("u4", 1, 32, 0);
      result("u4", 1, 11, 0);

      img = '0;
      rect(0, 0, 0, 0, 8);
      rect(1, 1, 1, 1, 8);
      rect(2, 2, 2, 2, 8);
      run_frame("diag8", 0, 32, 0);
      result("diag8", 1, 3, 0);
      run_frame("diag4", 1, 32, 0);
      result("diag4", 3, 1, 0);

      img = '0;
      for (int yy = 0; yy < 4; yy++)
         for (int xx = 0; xx < 8; xx++)
            if ((xx + yy) % 2 == 0) img[yy * 8 + xx] = 1'b1;
      run_frame("chk4", 1, 32, 0);
      result("chk4", 7, 1, 1);

      img = '0;
      run_frame("bg4", 1, 32, 0);
      result("bg4", 0, 0, 0);
      run_frame("bg8", 0, 32, 0);
      result("bg8", 0, 0, 0);

      for (int yy = 0; yy < 4; yy++)
         for (int xx = 0; xx < 8; xx++)
            if ((xx + yy) % 2 == 0) img[yy * 8 + xx] = 1'b1;
      run_frame("chk8", 0, 32, 0);
      result("chk8", 1, 16, 0);

      img = '0;
      rect(0, 0, 7, 4, 16);
      rect(12, 6, 13, 7, 16);
      run_frame("thr_small", 2, 128, 0);
      result("thr_small", 1, 40, 0);
      img = '0;
      rect(0, 0, 7, 4, 16);
      rect(12, 6, 14, 7, 16);
      run_frame("thr_big", 2, 128, 0);
      result("thr_big", 2, 40, 0);

      img = '0;
      rect(0, 0, 7, 3, 8);
      run_frame("sat", 3, 32, 0);
      result("sat", 1, 15, 0);

      img = '0;
      rect(1, 0, 1, 3, 8);
      rect(5, 0, 5, 3, 8);
      rect(1, 3, 5, 3, 8);
      start[0] = 1'b1;
      @(negedge clk);
      start[0] = 1'b0;
      for (int g = 0; g < 100 && !ready[0]; g++) @(negedge clk);
      valid[0] = 1'b1;
      for (int i = 0; i < 10; i++) begin
         pixel[0] = img[i];
         @(negedge clk);
      end
      check("mid_busy", 32'(busy[0]), 1);
      rst      = 1'b1;
      valid[0] = 1'b0;
      @(negedge clk);
      check("mid_rst_ready", 32'(ready[0]), 0);
      check("mid_rst_busy", 32'(busy[0]), 0);
      check("mid_rst_count", 32'(cnt[0]), 0);
      check("mid_rst_max", 32'(m0), 0);
      check("mid_rst_ovf", 32'(ovf[0]), 0);
      rst = 1'b0;
      @(negedge clk);
      p0 = pulses;
      run_frame("stall", 0, 32, 1);
      result("stall", 1, 11, 0);
      repeat (5) @(negedge clk);
      check("stall_pulses", pulses - p0, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
